// File: rtl/wb_mux_pkg.sv
// Shared types and sizing helpers for the Wishbone 1-to-N mux with timeout.
package wb_mux_pkg;

    localparam int IDX_W           = 4;
    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERR    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_UNMAPPED = 2'd1,
        CAUSE_TIMEOUT  = 2'd2
    } cause_t;

    // A disabled watchdog still gets a 1-bit counter so no vector collapses to zero width.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

    localparam int CNT_W = cnt_width(TIMEOUT_DEFAULT);

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational base/mask address decoder; the lowest matching slave index wins.
module wb_addr_decode
    import wb_mux_pkg::*;
#(
    parameter int                       NUM_SLAVES = 9,
    parameter logic [NUM_SLAVES*32-1:0] MATCH_ADDR = {NUM_SLAVES{32'h0}},
    parameter logic [NUM_SLAVES*32-1:0] MATCH_MASK = {NUM_SLAVES{32'hffffffff}}
) (
    input  logic [31:0]      adr,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    // Scanning from the top down lets the lowest index overwrite any higher match.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((adr & MATCH_MASK[i*32 +: 32]) == (MATCH_ADDR[i*32 +: 32] & MATCH_MASK[i*32 +: 32])) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/wb_mux_tmo.sv
// Wishbone classic 1-master/N-slave mux with registered decode, default-slave error,
// per-transaction watchdog and last-fault capture.
module wb_mux_tmo
    import wb_mux_pkg::*;
#(
    parameter int                       NUM_SLAVES     = 9,
    parameter logic [NUM_SLAVES*32-1:0] MATCH_ADDR     = {NUM_SLAVES{32'h0}},
    parameter logic [NUM_SLAVES*32-1:0] MATCH_MASK     = {NUM_SLAVES{32'hffffffff}},
    parameter int                       TIMEOUT_CYCLES = 255
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic [31:0]                wbm_adr_i,
    input  logic [31:0]                wbm_dat_i,
    input  logic [3:0]                 wbm_sel_i,
    input  logic                       wbm_we_i,
    input  logic                       wbm_cyc_i,
    input  logic                       wbm_stb_i,
    output logic [31:0]                wbm_dat_o,
    output logic                       wbm_ack_o,
    output logic                       wbm_err_o,
    output logic                       wbm_rty_o,
    output logic [NUM_SLAVES*32-1:0]   wbs_adr_o,
    output logic [NUM_SLAVES*32-1:0]   wbs_dat_o,
    output logic [NUM_SLAVES*4-1:0]    wbs_sel_o,
    output logic [NUM_SLAVES-1:0]      wbs_we_o,
    output logic [NUM_SLAVES-1:0]      wbs_cyc_o,
    output logic [NUM_SLAVES-1:0]      wbs_stb_o,
    input  logic [NUM_SLAVES*32-1:0]   wbs_dat_i,
    input  logic [NUM_SLAVES-1:0]      wbs_ack_i,
    input  logic [NUM_SLAVES-1:0]      wbs_err_i,
    input  logic [NUM_SLAVES-1:0]      wbs_rty_i,
    output logic                       fault_valid_o,
    output logic [1:0]                 fault_cause_o,
    output logic [31:0]                fault_adr_o,
    output logic [1:0]                 dbg_state
);

    localparam int             CW    = cnt_width(TIMEOUT_CYCLES);
    localparam bit             WD_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0]  LIMIT = CW'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);

    // Handshake: a transfer is requested while cyc&stb are high and completes in the
    // cycle any of ack/err/rty is seen; the master must then leave one idle cycle.

    state_t            state, state_d;
    logic [IDX_W-1:0]  sel, sel_d;
    logic [CW-1:0]     cnt, cnt_d;
    cause_t            cause_q, cause_d;
    logic [31:0]       fadr_q;
    logic              fault_set;
    logic              dec_hit;
    logic [IDX_W-1:0]  dec_idx;
    logic [31:0]       sel_dat;
    logic              sel_ack, sel_err, sel_rty, resp;

    wb_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .MATCH_ADDR (MATCH_ADDR),
        .MATCH_MASK (MATCH_MASK)
    ) u_decode (
        .adr (wbm_adr_i),
        .hit (dec_hit),
        .idx (dec_idx)
    );

    assign wbs_adr_o = {NUM_SLAVES{wbm_adr_i}};
    assign wbs_dat_o = {NUM_SLAVES{wbm_dat_i}};
    assign wbs_sel_o = {NUM_SLAVES{wbm_sel_i}};
    assign wbs_we_o  = {NUM_SLAVES{wbm_we_i}};

    always_comb begin
        sel_dat = '0;
        sel_ack = 1'b0;
        sel_err = 1'b0;
        sel_rty = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel == IDX_W'(i)) begin
                sel_dat = wbs_dat_i[i*32 +: 32];
                sel_ack = wbs_ack_i[i];
                sel_err = wbs_err_i[i];
                sel_rty = wbs_rty_i[i];
            end
        end
    end

    assign resp = sel_ack | sel_err | sel_rty;

    // Strobes are gated by the live master cyc so an abort reaches the slave without delay.
    always_comb begin
        wbs_cyc_o = '0;
        wbs_stb_o = '0;
        if (state == ST_ACTIVE) begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                if (sel == IDX_W'(i)) begin
                    wbs_cyc_o[i] = wbm_cyc_i;
                    wbs_stb_o[i] = wbm_cyc_i & wbm_stb_i;
                end
            end
        end
    end

    always_comb begin
        state_d   = state;
        sel_d     = sel;
        cnt_d     = cnt;
        cause_d   = CAUSE_NONE;
        fault_set = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (wbm_cyc_i && wbm_stb_i) begin
                    if (dec_hit) begin
                        state_d = ST_ACTIVE;
                        sel_d   = dec_idx;
                        cnt_d   = '0;
                    end else begin
                        state_d   = ST_ERR;
                        cause_d   = CAUSE_UNMAPPED;
                        fault_set = 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
                if (!wbm_cyc_i || resp) begin
                    state_d = ST_IDLE;
                end else if (WD_EN && cnt == LIMIT) begin
                    state_d   = ST_ERR;
                    cause_d   = CAUSE_TIMEOUT;
                    fault_set = 1'b1;
                end else if (WD_EN) begin
                    cnt_d = cnt + CW'(1);
                end
            end
            ST_ERR: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state   <= ST_IDLE;
            sel     <= '0;
            cnt     <= '0;
            cause_q <= CAUSE_NONE;
            fadr_q  <= '0;
        end else begin
            state <= state_d;
            sel   <= sel_d;
            cnt   <= cnt_d;
            if (fault_set) begin
                cause_q <= cause_d;
                fadr_q  <= wbm_adr_i;
            end
        end
    end

    assign wbm_dat_o     = (state == ST_ACTIVE) ? sel_dat : 32'h0;
    assign wbm_ack_o     = (state == ST_ACTIVE) & sel_ack;
    assign wbm_rty_o     = (state == ST_ACTIVE) & sel_rty;
    assign wbm_err_o     = ((state == ST_ACTIVE) & sel_err) | (state == ST_ERR);
    assign fault_valid_o = (state == ST_ERR);
    assign fault_cause_o = cause_q;
    assign fault_adr_o   = fadr_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_wb_mux_tmo.sv
// Randomized scoreboard bench for wb_mux_tmo with a spec-level transaction model.
module tb_wb_mux_tmo;

    localparam int NS = 4;
    localparam int T  = 4;

    // Slave 3 lies entirely inside slave 0's window, so slave 0 must always win.
    localparam logic [NS*32-1:0] M_ADDR = {32'h1000_0000, 32'h0000_0000, 32'h2000_0000, 32'h1000_0000};
    localparam logic [NS*32-1:0] M_MASK = {32'hff00_0000, 32'hfffc_0000, 32'hf000_0000, 32'hf000_0000};
    localparam logic [31:0] BASE_A [NS] = '{32'h1000_0000, 32'h2000_0000, 32'h0000_0000, 32'h1000_0000};
    localparam logic [31:0] MASK_A [NS] = '{32'hf000_0000, 32'hf000_0000, 32'hfffc_0000, 32'hff00_0000};

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       wbm_adr, wbm_dat, wbm_rdat, fault_adr;
    logic [3:0]        wbm_sel;
    logic              wbm_we, wbm_cyc, wbm_stb, wbm_ack, wbm_err, wbm_rty, fault_valid;
    logic [1:0]        fault_cause, dbg_state;
    logic [NS*32-1:0]  wbs_adr, wbs_wdat, wbs_rdat;
    logic [NS*4-1:0]   wbs_sel;
    logic [NS-1:0]     wbs_we, wbs_cyc, wbs_stb, wbs_ack, wbs_err, wbs_rty;

    typedef struct {
        int          kind;   // 0 ack, 1 err, 2 rty
        logic [31:0] data;
        int          cyc;
        bit          fault;
        logic [1:0]  cause;
        logic [31:0] adr;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0, n_miss = 0, cyc_n = 0;
    int          plan_tgt = -1, plan_d = 0, plan_kind = 0, age = 0;
    logic [31:0] plan_data = '0;
    logic [1:0]  last_cause = 2'd0;
    logic [31:0] last_adr = '0;

    wb_mux_tmo #(
        .NUM_SLAVES     (NS),
        .MATCH_ADDR     (M_ADDR),
        .MATCH_MASK     (M_MASK),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .wbm_adr_i     (wbm_adr),
        .wbm_dat_i     (wbm_dat),
        .wbm_sel_i     (wbm_sel),
        .wbm_we_i      (wbm_we),
        .wbm_cyc_i     (wbm_cyc),
        .wbm_stb_i     (wbm_stb),
        .wbm_dat_o     (wbm_rdat),
        .wbm_ack_o     (wbm_ack),
        .wbm_err_o     (wbm_err),
        .wbm_rty_o     (wbm_rty),
        .wbs_adr_o     (wbs_adr),
        .wbs_dat_o     (wbs_wdat),
        .wbs_sel_o     (wbs_sel),
        .wbs_we_o      (wbs_we),
        .wbs_cyc_o     (wbs_cyc),
        .wbs_stb_o     (wbs_stb),
        .wbs_dat_i     (wbs_rdat),
        .wbs_ack_i     (wbs_ack),
        .wbs_err_i     (wbs_err),
        .wbs_rty_i     (wbs_rty),
        .fault_valid_o (fault_valid),
        .fault_cause_o (fault_cause),
        .fault_adr_o   (fault_adr),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got %0d cycles required fewer", cyc_n);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic int model_decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++)
            if ((a & MASK_A[i]) == (BASE_A[i] & MASK_A[i])) return i;
        return -1;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // ---------------- slave responder ----------------
    always begin
        @(posedge clk);
        #2;
        wbs_ack  = '0;
        wbs_err  = '0;
        wbs_rty  = '0;
        wbs_rdat = {$urandom, $urandom, $urandom, $urandom};
        if (!rst) begin
            for (int j = 0; j < NS; j++) begin
                if (j != plan_tgt && $urandom_range(0, 3) == 0) begin
                    case ($urandom_range(0, 2))
                        0:       wbs_ack[j] = 1'b1;
                        1:       wbs_err[j] = 1'b1;
                        default: wbs_rty[j] = 1'b1;
                    endcase
                end
            end
            if (plan_tgt >= 0 && wbs_stb[plan_tgt]) begin
                if (age == plan_d) begin
                    wbs_rdat[plan_tgt*32 +: 32] = plan_data;
                    case (plan_kind)
                        0:       wbs_ack[plan_tgt] = 1'b1;
                        1:       wbs_err[plan_tgt] = 1'b1;
                        default: wbs_rty[plan_tgt] = 1'b1;
                    endcase
                end
                age++;
            end else begin
                age = 0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        exp_t          e;
        logic [NS-1:0] m;
        logic [2:0]    ef;
        if (!rst) begin
            if (wbs_stb != '0 || wbs_cyc != '0) begin
                m = (plan_tgt >= 0) ? (NS'(1) << plan_tgt) : '0;
                check("slave_stb", 128'(wbs_stb), 128'(m));
                check("slave_cyc", 128'(wbs_cyc), 128'(m));
                check("bcast_adr", 128'(wbs_adr), 128'({NS{wbm_adr}}));
                check("bcast_wdat", 128'(wbs_wdat), 128'({NS{wbm_dat}}));
                check("bcast_sel_we", 128'({wbs_sel, wbs_we}), 128'({{NS{wbm_sel}}, {NS{wbm_we}}}));
            end
            if (fault_valid) check("fault_with_err", 128'(wbm_err), 128'(1));
            if (wbm_ack || wbm_err || wbm_rty) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_resp: got ack/err/rty=%b required no response", {wbm_ack, wbm_err, wbm_rty});
                end else begin
                    e  = exp_q.pop_front();
                    ef = (e.kind == 0) ? 3'b100 : (e.kind == 1) ? 3'b010 : 3'b001;
                    if (e.fault) begin
                        last_cause = e.cause;
                        last_adr   = e.adr;
                    end
                    check("resp_kind", 128'({wbm_ack, wbm_err, wbm_rty}), 128'(ef));
                    check("resp_data", 128'(wbm_rdat), 128'(e.data));
                    check("resp_cycle", 128'(cyc_n), 128'(e.cyc));
                    check("fault_valid", 128'(fault_valid), 128'(e.fault));
                    check("fault_cause", 128'(fault_cause), 128'(last_cause));
                    check("fault_adr", 128'(fault_adr), 128'(last_adr));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [31:0] a, input bit we, input int d, input int kind, input logic [31:0] data);
        exp_t e;
        int   idx;
        bit   got;
        @(posedge clk);
        #1;
        idx       = model_decode(a);
        plan_tgt  = idx;
        plan_d    = d;
        plan_kind = kind;
        plan_data = data;
        e.adr   = a;
        e.fault = 1'b0;
        e.cause = 2'd0;
        e.kind  = 1;
        e.data  = 32'h0;
        if (idx < 0) begin
            e.cyc   = cyc_n + 1;
            e.fault = 1'b1;
            e.cause = 2'd1;
        end else if (d < T) begin
            e.kind = kind;
            e.data = data;
            e.cyc  = cyc_n + 1 + d;
        end else begin
            e.cyc   = cyc_n + 1 + T;
            e.fault = 1'b1;
            e.cause = 2'd2;
        end
        exp_q.push_back(e);
        wbm_adr = a;
        wbm_we  = we;
        wbm_dat = $urandom;
        wbm_sel = 4'($urandom_range(0, 15));
        wbm_cyc = 1'b1;
        wbm_stb = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            got = wbm_ack | wbm_err | wbm_rty;
        end
        if (!got) begin
            n_vec++;
            n_miss++;
            $display("FAIL resp_wait: got no response in 40 cycles for adr %h, required one", a);
            if (exp_q.size() > 0) void'(exp_q.pop_back());
        end
        @(posedge clk);
        #1;
        wbm_cyc = 1'b0;
        wbm_stb = 1'b0;
    endtask

    task automatic start_stall(input logic [31:0] a, input int tgt, output bit seen);
        @(posedge clk);
        #1;
        plan_tgt = tgt;
        plan_d   = 1000;
        wbm_adr  = a;
        wbm_we   = 1'b0;
        wbm_cyc  = 1'b1;
        wbm_stb  = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = wbs_stb[tgt];
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit          seen;
        logic [31:0] a;
        rst = 1'b1;
        wbm_adr = '0; wbm_dat = '0; wbm_sel = '0;
        wbm_we = 1'b0; wbm_cyc = 1'b0; wbm_stb = 1'b0;
        @(posedge clk);
        #1;
        check("rst_state", 128'(dbg_state), 128'(0));
        check("rst_slave_cyc_stb", 128'({wbs_cyc, wbs_stb}), 128'(0));
        check("rst_resp", 128'({wbm_ack, wbm_err, wbm_rty}), 128'(0));
        check("rst_rdat", 128'(wbm_rdat), 128'(0));
        check("rst_fault", 128'({fault_valid, fault_cause, fault_adr}), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        issue(32'h0000_0010, 1'b0, 1, 0, 32'hDEAD_BEEF);   // slave 2, ack 1 cycle after stb
        issue(32'h5000_0000, 1'b1, 0, 0, 32'h0);           // unmapped
        issue(32'h2000_0100, 1'b0, 7, 0, 32'h1111_2222);   // slave never answers
        issue(32'h2000_0200, 1'b0, 3, 0, 32'hCAFE_F00D);   // ack as counter hits limit
        issue(32'h1000_0040, 1'b1, 0, 0, 32'h1234_5678);   // overlap 0/3
        issue(32'h1000_0044, 1'b0, 2, 2, 32'h0BAD_0BAD);   // slave retry
        issue(32'h0000_0020, 1'b0, 1, 1, 32'h5555_AAAA);   // slave error

        // Master abort mid-transfer.
        start_stall(32'h0000_0100, 2, seen);
        check("abort_reached_active", 128'(seen), 128'(1));
        @(posedge clk);
        #1;
        wbm_cyc = 1'b0;
        wbm_stb = 1'b0;
        #1;
        check("abort_cyc_same_cycle", 128'({wbs_cyc, wbs_stb}), 128'(0));
        @(posedge clk);
        #1;
        check("abort_idle", 128'(dbg_state), 128'(0));
        check("abort_no_fault", 128'({fault_valid, wbm_err}), 128'(0));
        plan_tgt = -1;

        // Asynchronous reset mid-transfer; fault cause is still 2 from the earlier timeout.
        start_stall(32'h2000_0010, 1, seen);
        check("rst_mid_reached_active", 128'(seen), 128'(1));
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_slave", 128'({wbs_cyc, wbs_stb}), 128'(0));
        check("rst_mid_resp", 128'({wbm_ack, wbm_err, wbm_rty, wbm_rdat}), 128'(0));
        check("rst_mid_fault", 128'({fault_valid, fault_cause, fault_adr}), 128'(0));
        check("rst_mid_state", 128'(dbg_state), 128'(0));
        wbm_cyc = 1'b0;
        wbm_stb = 1'b0;
        plan_tgt   = -1;
        last_cause = 2'd0;
        last_adr   = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 4))
                0:       a = 32'h1000_0000 | ($urandom & 32'h0fff_ffff);
                1:       a = 32'h2000_0000 | ($urandom & 32'h0fff_ffff);
                2:       a = $urandom & 32'h0003_fffc;
                3:       a = $urandom;
                default: a = 32'h0004_0000 | ($urandom & 32'h0fff_ffff);
            endcase
            issue(a, 1'($urandom_range(0, 1)), $urandom_range(0, 6),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0, $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (5) @(posedge clk);
        check("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
